// File: rtl/reg_file_scoreboard.sv
// 32 x DATA_W register file with write-through bypass and a per-register pending-write scoreboard.
// Reads, Busy and Stall are combinational (0 cycles); writes, counters and ScoreErr update at the rising edge.
// Stall holds decode while a used source has an outstanding write; a stalled issue is never counted.
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              WriteRegEnable,
  input  logic [4:0]        RegFileWriteReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  input  logic              UseRs1,
  input  logic              UseRs2,
  input  logic              IssueValid,
  input  logic [4:0]        IssueDestReg,
  input  logic              Flush,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Stall,
  output logic              ScoreErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Register storage; entry 0 is reset and never written, so it always reads as zero.
  logic [DATA_W-1:0] regs_q [32];

  // Pending-write counters; entry 0 is held at zero.
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];

  logic              err_q;
  logic              err_d;

  // A write-back to r0 is neither a write nor a scoreboard release.
  logic              wr_en;
  logic              rel_hit1;
  logic              rel_hit2;
  logic              busy1;
  logic              busy2;
  logic              issue_acc;

  assign wr_en    = WriteRegEnable && (RegFileWriteReg != 5'd0);
  assign rel_hit1 = wr_en && (RegFileWriteReg == ReadReg1);
  assign rel_hit2 = wr_en && (RegFileWriteReg == ReadReg2);

  // Operand read with same-cycle bypass of the write-back value.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (rel_hit1) begin
      ReadData1 = writeData;
    end else if (ReadReg1 != 5'd0) begin
      ReadData1 = regs_q[ReadReg1];
    end
    if (rel_hit2) begin
      ReadData2 = writeData;
    end else if (ReadReg2 != 5'd0) begin
      ReadData2 = regs_q[ReadReg2];
    end
  end

  // Busy looks at the count left after this cycle's release, so the last
  // outstanding write completing in this cycle does not stall its consumer.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (ReadReg1 != 5'd0) begin
      busy1 = rel_hit1 ? (cnt_q[ReadReg1] > CNT_ONE) : (cnt_q[ReadReg1] != '0);
    end
    if (ReadReg2 != 5'd0) begin
      busy2 = rel_hit2 ? (cnt_q[ReadReg2] > CNT_ONE) : (cnt_q[ReadReg2] != '0);
    end
  end

  assign Stall     = (UseRs1 && busy1) || (UseRs2 && busy2);
  assign issue_acc = IssueValid && !Stall && (IssueDestReg != 5'd0);
  assign ScoreErr  = err_q;

  // Counter next state: flush wins; issue+release on one register cancel;
  // saturating increment/decrement flags overflow and underflow as errors.
  always_comb begin
    logic inc;
    logic dec;
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      inc      = issue_acc && (IssueDestReg == 5'(i));
      dec      = wr_en && (RegFileWriteReg == 5'(i));
      if (Flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[i] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  // Register write; a flush in the same cycle does not suppress it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[RegFileWriteReg] <= writeData;
    end
  end

  // Scoreboard counters and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: a vector table stepped once per
// clock plus hand-written sequences for reset pulses and error flagging.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        WriteRegEnable;
  logic [4:0]  RegFileWriteReg;
  logic [31:0] writeData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        UseRs1;
  logic        UseRs2;
  logic        IssueValid;
  logic [4:0]  IssueDestReg;
  logic        Flush;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Stall;
  logic        ScoreErr;

  int checks   = 0;
  int failures = 0;

  reg_file_scoreboard #(.DATA_W(32), .CNT_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .WriteRegEnable (WriteRegEnable),
    .RegFileWriteReg(RegFileWriteReg),
    .writeData      (writeData),
    .ReadReg1       (ReadReg1),
    .ReadReg2       (ReadReg2),
    .UseRs1         (UseRs1),
    .UseRs2         (UseRs2),
    .IssueValid     (IssueValid),
    .IssueDestReg   (IssueDestReg),
    .Flush          (Flush),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .Stall          (Stall),
    .ScoreErr       (ScoreErr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  r2;
    logic        u2;
    logic        iv;
    logic [4:0]  idst;
    logic        fl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        es;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [4:0] wreg, input logic [31:0] wd,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic iv, input logic [4:0] idst, input logic fl,
                     input logic [31:0] e1, input logic [31:0] e2, input logic es, input logic ee);
    vec_t v;
    v.we = we; v.wreg = wreg; v.wd = wd; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
    v.iv = iv; v.idst = idst; v.fl = fl; v.e1 = e1; v.e2 = e2; v.es = es; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wd,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic iv, input logic [4:0] idst, input logic fl);
    WriteRegEnable = we; RegFileWriteReg = wreg; writeData = wd;
    ReadReg1 = r1; UseRs1 = u1; ReadReg2 = r2; UseRs2 = u2;
    IssueValid = iv; IssueDestReg = idst; Flush = fl;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [31:0] e1,
                         input logic [31:0] e2, input logic es, input logic ee);
    chk({tag, ".rd1"},   idx, ReadData1, e1);
    chk({tag, ".rd2"},   idx, ReadData2, e2);
    chk({tag, ".stall"}, idx, {31'd0, Stall}, {31'd0, es});
    chk({tag, ".err"},   idx, {31'd0, ScoreErr}, {31'd0, ee});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    //  we wreg wdata        r1 u1 r2 u2 iv idst fl  exp_rd1       exp_rd2       st er
    add(0, 0,  32'h0,        0, 0, 0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0); // 0 reset state
    add(1, 5,  32'hDEADBEEF, 5, 0, 0, 0, 0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0); // 1 bypass r5
    add(1, 0,  32'h1234,     5, 0, 0, 0, 0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 1); // 2 stored r5, r0 no bypass
    add(0, 0,  32'h0,        0, 0, 0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 1); // 3 r0 still 0
    add(1, 7,  32'hA5A5A5A5, 5, 0, 7, 0, 0, 0,  0,  32'hDEADBEEF, 32'hA5A5A5A5, 0, 1); // 4 bypass on port 2
    add(0, 0,  32'h0,        7, 0, 5, 0, 0, 0,  0,  32'hA5A5A5A5, 32'hDEADBEEF, 0, 1); // 5 stored values
    add(0, 0,  32'h0,        3, 0, 0, 0, 1, 3,  0,  32'h0,        32'h0,        0, 1); // 6 issue r3
    add(1, 3,  32'h33,       3, 1, 0, 0, 0, 0,  0,  32'h33,       32'h0,        0, 1); // 7 release r3 unstalls
    add(0, 0,  32'h0,        3, 1, 0, 0, 0, 0,  0,  32'h33,       32'h0,        0, 1); // 8 counter[3]=0
    add(0, 0,  32'h0,        3, 0, 0, 0, 1, 3,  0,  32'h33,       32'h0,        0, 1); // 9 issue r3
    add(0, 0,  32'h0,        3, 1, 0, 0, 1, 10, 0,  32'h33,       32'h0,        1, 1); // 10 stall, r10 issue dropped
    add(0, 0,  32'h0,        3, 0, 10,1, 0, 0,  0,  32'h33,       32'h0,        0, 1); // 11 r10 not busy
    add(1, 3,  32'h3,        3, 1, 0, 0, 0, 0,  0,  32'h3,        32'h0,        0, 1); // 12 release r3
    add(0, 0,  32'h0,        3, 1, 0, 0, 0, 0,  0,  32'h3,        32'h0,        0, 1); // 13
    add(0, 0,  32'h0,        4, 0, 0, 0, 1, 4,  0,  32'h0,        32'h0,        0, 1); // 14 issue r4 #1
    add(0, 0,  32'h0,        4, 0, 0, 0, 1, 4,  0,  32'h0,        32'h0,        0, 1); // 15 #2
    add(0, 0,  32'h0,        4, 0, 0, 0, 1, 4,  0,  32'h0,        32'h0,        0, 1); // 16 #3
    add(0, 0,  32'h0,        4, 0, 0, 0, 1, 4,  0,  32'h0,        32'h0,        0, 1); // 17 #4 overflow
    add(0, 0,  32'h0,        4, 1, 0, 0, 0, 0,  0,  32'h0,        32'h0,        1, 1); // 18 saturated at 3
    add(1, 4,  32'h40,       4, 1, 0, 0, 0, 0,  0,  32'h40,       32'h0,        1, 1); // 19 eff 2
    add(1, 4,  32'h41,       4, 1, 0, 0, 0, 0,  0,  32'h41,       32'h0,        1, 1); // 20 eff 1
    add(1, 4,  32'h42,       4, 1, 0, 0, 0, 0,  0,  32'h42,       32'h0,        0, 1); // 21 eff 0
    add(1, 9,  32'h9,        4, 1, 9, 1, 0, 0,  0,  32'h42,       32'h9,        0, 1); // 22 underflow r9
    add(0, 0,  32'h0,        4, 1, 9, 1, 0, 0,  0,  32'h42,       32'h9,        0, 1); // 23 r9 stays 0
    add(0, 0,  32'h0,        0, 0, 0, 0, 1, 2,  0,  32'h0,        32'h0,        0, 1); // 24 issue r2
    add(0, 0,  32'h0,        0, 0, 0, 0, 1, 2,  0,  32'h0,        32'h0,        0, 1); // 25 issue r2
    add(0, 0,  32'h0,        0, 0, 0, 0, 1, 6,  0,  32'h0,        32'h0,        0, 1); // 26 issue r6
    add(0, 0,  32'h0,        2, 1, 6, 1, 0, 0,  0,  32'h0,        32'h0,        1, 1); // 27 both busy
    add(1, 2,  32'hCAFE0002, 2, 1, 6, 0, 1, 11, 1,  32'hCAFE0002, 32'h0,        1, 1); // 28 flush + release r2
    add(0, 0,  32'h0,        2, 1, 6, 1, 0, 0,  0,  32'hCAFE0002, 32'h0,        0, 1); // 29 all cleared
    add(0, 0,  32'h0,        12,0, 0, 0, 1, 12, 0,  32'h0,        32'h0,        0, 1); // 30 issue r12
    add(1, 12, 32'h12,       12,1, 0, 0, 1, 12, 0,  32'h12,       32'h0,        0, 1); // 31 issue+release r12
    add(0, 0,  32'h0,        12,1, 0, 0, 0, 0,  0,  32'h12,       32'h0,        1, 1); // 32 counter[12] still 1
    add(1, 12, 32'h1212,     12,1, 0, 0, 0, 0,  0,  32'h1212,     32'h0,        0, 1); // 33 release r12
    add(0, 0,  32'h0,        12,1, 11,1, 0, 0,  0,  32'h1212,     32'h0,        0, 1); // 34 r11 never counted

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wd, vecs[i].r1, vecs[i].u1,
            vecs[i].r2, vecs[i].u2, vecs[i].iv, vecs[i].idst, vecs[i].fl);
      #2;
      chk_out("vec", i, vecs[i].e1, vecs[i].e2, vecs[i].es, vecs[i].ee);
    end

    // Mid-cycle reset pulse with r8=0x55 and one write outstanding on r8.
    @(negedge clk);
    drive(1, 8, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 8, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 8, 1, 0, 0, 0, 0, 0);
    #2;
    chk_out("pre_rst", 0, 32'h55, 32'h0, 1, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_out("in_rst", 0, 32'h0, 32'h0, 0, 0);
    WriteRegEnable = 1'b1; RegFileWriteReg = 5'd8; writeData = 32'h77;
    #1;
    chk("in_rst.bypass", 0, ReadData1, 32'h77);
    #1;
    idle();
    ReadReg1 = 5'd8; UseRs1 = 1'b1;
    reset_n = 1'b1;
    #1;
    chk_out("post_rst", 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    #2;
    chk_out("post_rst", 1, 32'h0, 32'h0, 0, 0);

    // Overflow alone sets the error flag, one edge after the fourth issue.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 4, 0);
      #2;
      chk("ovf.err_before", k, {31'd0, ScoreErr}, 32'd0);
    end
    @(negedge clk);
    drive(0, 0, 32'h0, 4, 1, 0, 0, 0, 0, 0);
    #2;
    chk("ovf.err", 0, {31'd0, ScoreErr}, 32'd1);
    chk("ovf.stall", 0, {31'd0, Stall}, 32'd1);

    // Underflow alone sets the error flag and leaves the counter at zero.
    reset_pulse();
    #2;
    chk("unf.err_cleared", 0, {31'd0, ScoreErr}, 32'd0);
    @(negedge clk);
    drive(1, 9, 32'h99, 0, 0, 9, 1, 0, 0, 0);
    #2;
    chk_out("unf", 0, 32'h0, 32'h99, 0, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 9, 1, 0, 0, 0);
    #2;
    chk_out("unf", 1, 32'h0, 32'h99, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter: DATA_W, default 32, width of each register and of the data ports.
REQ-002 Parameter: CNT_W, default 2, width of the per-register pending-write counter.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: WriteRegEnable  input  1  write-back write strobe.
REQ-006 Port: RegFileWriteReg  input  5  write-back destination register index.
REQ-007 Port: writeData  input  DATA_W  write-back data.
REQ-008 Port: ReadReg1 / ReadReg2  input  5 each  decode source register indices.
REQ-009 Port: UseRs1 / UseRs2  input  1 each  decode instruction actually reads that source.
REQ-010 Port: IssueValid  input  1  decode is issuing an instruction that will write a register.
REQ-011 Port: IssueDestReg  input  5  destination index of the issuing instruction.
REQ-012 Port: Flush  input  1  synchronous clear of all pending-write counters.
REQ-013 Port: ReadData1 / ReadData2  output  DATA_W each  source operand values.
REQ-014 Port: Stall  output  1  decode must hold the current instruction this cycle.
REQ-015 Port: ScoreErr  output  1  sticky counter overflow/underflow flag.

Function
REQ-016 Storage SHALL be 32 registers of DATA_W bits; register 0 SHALL read as 0 and SHALL never be written.
REQ-017 A write SHALL occur at the clock edge when WriteRegEnable=1 and RegFileWriteReg!=0.
REQ-018 Reads SHALL be combinational; ReadDataN SHALL equal writeData when WriteRegEnable=1, RegFileWriteReg==ReadRegN and ReadRegN!=0 (same-cycle write-through bypass); otherwise the stored value.
REQ-019 Each register 1..31 SHALL have a CNT_W-bit pending counter; register 0's counter SHALL be constant 0.
REQ-020 Accepted issue = IssueValid & !Stall & IssueDestReg!=0; increments the counter of IssueDestReg at the edge.
REQ-021 Release = WriteRegEnable & RegFileWriteReg!=0; decrements the counter of RegFileWriteReg at the edge.
REQ-022 Accepted issue and release of the same register in one cycle SHALL leave that counter unchanged.
REQ-023 BusyN SHALL be the effective count of ReadRegN != 0, where effective count is the stored count minus 1 if a release targets ReadRegN this cycle; a count of 1 being released SHALL NOT stall.
REQ-024 Stall SHALL equal (UseRs1 & Busy1) | (UseRs2 & Busy2), combinational, no registered latency.
REQ-025 Accepted issue to a counter at max value (2^CNT_W-1) SHALL leave the counter saturated and set ScoreErr.
REQ-026 Release of a counter at 0 SHALL leave it at 0 and set ScoreErr.
REQ-027 ScoreErr SHALL remain set until reset.
REQ-028 Flush=1 SHALL clear all counters at the edge, taking priority over issue and release in that cycle; a register write in the same cycle SHALL still occur.

Reset
REQ-029 reset_n=0 SHALL asynchronously clear all registers, all counters and ScoreErr.
REQ-030 While reset_n=0, ReadData1/2 SHALL be 0 (except bypass of writeData), Stall=0 and ScoreErr=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL behave as from the empty state.

Verification
REQ-032 Write r5=0xDEADBEEF, next cycle ReadReg1=5 -> ReadData1=0xDEADBEEF; write r0=0x1234 -> ReadData of r0 stays 0.
REQ-033 WriteRegEnable=1, RegFileWriteReg=7, writeData=0xA5A5A5A5, ReadReg2=7 in the same cycle -> ReadData2=0xA5A5A5A5 combinationally.
REQ-034 Issue dest r3; next cycle ReadReg1=3, UseRs1=1 -> Stall=1; release r3 in the same cycle -> Stall=0 combinationally; next cycle counter[3]=0.
REQ-035 Issue r4 three times, then issue r4 again -> ScoreErr=1 and counter[4]=3; release r9 with counter 0 -> ScoreErr remains 1, counter[9]=0.
REQ-036 Counters r2=2, r6=1; assert Flush together with a release of r2 -> all counters 0 next cycle, and r2 holds the written data.
REQ-037 With r8=0x55 and counter[8]=1, pulse reset_n low between edges -> ReadData of r8=0, Stall=0, ScoreErr=0 immediately, and state stays cleared after release.
